// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: per-channel FSM state encoding,
// clock-rate defaults and the counter sizing helper.
package key_debounce_pkg;

  typedef enum logic [2:0] {
    ST_RELEASED    = 3'd0,
    ST_PRESS_CHK   = 3'd1,
    ST_PRESSED     = 3'd2,
    ST_HOLD        = 3'd3,
    ST_RELEASE_CHK = 3'd4
  } state_t;

  // Defaults assume a 50 MHz clock: 20 ms debounce, 0.5 s hold, 0.1 s repeat.
  localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int unsigned DEF_HOLD_CYC     = 25_000_000;
  localparam int unsigned DEF_REPEAT_CYC   = 5_000_000;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchronizer, debounce/hold FSM and its counters,
// producing a clean level plus press, release and auto-repeat strobes.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  if (DEBOUNCE_CYC == 0) begin : g_bad_debounce
    $error("key_debounce_ch: DEBOUNCE_CYC must be at least 1");
  end
  if (HOLD_CYC == 0) begin : g_bad_hold
    $error("key_debounce_ch: HOLD_CYC must be at least 1");
  end

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC);
  localparam logic [CW-1:0] DB_LAST   = CW'((DEBOUNCE_CYC == 0) ? 0 : DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_CYC == 0) ? 0 : REPEAT_CYC - 1);
  localparam logic REPEAT_EN = (REPEAT_CYC != 0);

  logic          sync1_reg;
  logic          sync2_reg;
  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] hold_cnt_reg;
  logic          held_hold_reg;
  logic          level_reg;
  logic          press_reg;
  logic          release_reg;
  logic          repeat_reg;

  logic          raw;
  logic          hold_phase;
  logic [CW-1:0] hold_last;
  logic          hold_at_last;
  logic          hold_tick;
  logic [CW-1:0] hold_cnt_next;

  assign raw = ~sync2_reg;

  // Hold timer runs in PRESSED, HOLD and RELEASE_CHK; the threshold depends on
  // whether the first repeat has already fired (held flag while checking release).
  always_comb begin
    hold_phase = 1'b0;
    case (state_reg)
      ST_HOLD:        hold_phase = 1'b1;
      ST_RELEASE_CHK: hold_phase = held_hold_reg;
      default:        hold_phase = 1'b0;
    endcase
    hold_last     = hold_phase ? REP_LAST : HOLD_LAST;
    hold_at_last  = (hold_cnt_reg == hold_last);
    hold_tick     = hold_at_last && REPEAT_EN;
    hold_cnt_next = hold_cnt_reg + 1'b1;
    if (hold_at_last) begin
      hold_cnt_next = REPEAT_EN ? '0 : hold_cnt_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg     <= 1'b1;
      sync2_reg     <= 1'b1;
      state_reg     <= ST_RELEASED;
      cnt_reg       <= '0;
      hold_cnt_reg  <= '0;
      held_hold_reg <= 1'b0;
      level_reg     <= 1'b0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
      repeat_reg    <= 1'b0;
    end else begin
      sync1_reg   <= key_n;
      sync2_reg   <= sync1_reg;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      repeat_reg  <= 1'b0;
      case (state_reg)
        ST_RELEASED: begin
          if (raw) begin
            state_reg <= ST_PRESS_CHK;
            cnt_reg   <= '0;
          end
        end
        ST_PRESS_CHK: begin
          if (!raw) begin
            state_reg <= ST_RELEASED;
            cnt_reg   <= '0;
          end else if (cnt_reg == DB_LAST) begin
            state_reg    <= ST_PRESSED;
            cnt_reg      <= '0;
            hold_cnt_reg <= '0;
            level_reg    <= 1'b1;
            press_reg    <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_PRESSED, ST_HOLD: begin
          hold_cnt_reg <= hold_cnt_next;
          if (!raw) begin
            // A tick landing on this edge is dropped but still advances the cadence.
            state_reg     <= ST_RELEASE_CHK;
            cnt_reg       <= '0;
            held_hold_reg <= (state_reg == ST_HOLD) || hold_tick;
          end else if (hold_tick) begin
            state_reg  <= ST_HOLD;
            repeat_reg <= 1'b1;
          end
        end
        ST_RELEASE_CHK: begin
          if (raw) begin
            state_reg    <= (held_hold_reg || hold_tick) ? ST_HOLD : ST_PRESSED;
            hold_cnt_reg <= hold_cnt_next;
          end else if (cnt_reg == DB_LAST) begin
            state_reg     <= ST_RELEASED;
            cnt_reg       <= '0;
            hold_cnt_reg  <= '0;
            held_hold_reg <= 1'b0;
            level_reg     <= 1'b0;
            release_reg   <= 1'b1;
          end else begin
            cnt_reg      <= cnt_reg + 1'b1;
            hold_cnt_reg <= hold_cnt_next;
            if (hold_tick) begin
              held_hold_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_RELEASED;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign key_level     = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign repeat_pulse  = repeat_reg;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: one independent key_debounce_ch per raw active-low pin,
// all on the same clock and reset.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int          N_KEYS       = 2,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  if (N_KEYS < 1) begin : g_bad_keys
    $error("key_debounce: N_KEYS must be at least 1");
  end

  genvar gi;
  for (gi = 0; gi < N_KEYS; gi++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_n         (key_n[gi]),
      .key_level     (key_level[gi]),
      .press_pulse   (press_pulse[gi]),
      .release_pulse (release_pulse[gi]),
      .repeat_pulse  (repeat_pulse[gi])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues the expected strobes with
// their due cycle, a negedge monitor pops and compares them against the outputs.
module tb_key_debounce;
  localparam int N    = 2;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;
  localparam int LAT  = 2 + DB;   // pin sampling edge to strobe edge

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_REP   = 2;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] key_level;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] repeat_pulse;

  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  ev_t          exp_q[$];
  logic [N-1:0] exp_level = '0;

  key_debounce #(
    .N_KEYS       (N),
    .DEBOUNCE_CYC (DB),
    .HOLD_CYC     (HOLD),
    .REPEAT_CYC   (REP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_n         (key_n),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [N-1:0] act, logic [N-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp_v);
    end
  endfunction

  // Monitor: gather everything due this cycle, then compare all outputs.
  always @(negedge clk) begin
    logic [N-1:0] ep;
    logic [N-1:0] er;
    logic [N-1:0] et;
    ev_t e;
    ep = '0;
    er = '0;
    et = '0;
    if (!rst_n) exp_level = '0;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_expect ch%0d kind %0d: due cycle %0d, now %0d", e.ch, e.kind, e.cyc, cyc);
      end else begin
        case (e.kind)
          K_PRESS: begin ep[e.ch] = 1'b1; exp_level[e.ch] = 1'b1; end
          K_REL:   begin er[e.ch] = 1'b1; exp_level[e.ch] = 1'b0; end
          default: et[e.ch] = 1'b1;
        endcase
      end
    end
    chk("press_pulse", press_pulse, ep);
    chk("release_pulse", release_pulse, er);
    chk("repeat_pulse", repeat_pulse, et);
    chk("key_level", key_level, exp_level);
    for (int c = 0; c < N; c++) begin
      if (ep[c]) $display("cycle %0d ch%0d press   seen=%0b", cyc, c, press_pulse[c]);
      if (er[c]) $display("cycle %0d ch%0d release seen=%0b", cyc, c, release_pulse[c]);
      if (et[c]) $display("cycle %0d ch%0d repeat  seen=%0b", cyc, c, repeat_pulse[c]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c, input int kind, input int ch);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.ch   = ch;
    exp_q.push_back(e);
  endtask

  // Hold the masked keys low for low_cyc sampling edges, then release them.
  task automatic hold_keys(input logic [N-1:0] mask, input int low_cyc);
    int t;
    int p;
    key_n = key_n & ~mask;
    t = cyc + 1;
    p = t + LAT;
    for (int c = 0; c < N; c++) if (mask[c]) push(p, K_PRESS, c);
    for (int e = p + HOLD; e <= t + low_cyc + 1; e += (e == p + HOLD) ? REP : REP) begin
      for (int c = 0; c < N; c++) if (mask[c]) push(e, K_REP, c);
    end
    for (int c = 0; c < N; c++) if (mask[c]) push(t + low_cyc + LAT, K_REL, c);
    step(low_cyc);
    key_n = key_n | mask;
    step(LAT + 4);
  endtask

  task automatic glitch_test();
    int t;
    int p;
    int offs[6];
    offs = '{10, 13, 16, 22, 25, 28};
    key_n[0] = 1'b0;
    t = cyc + 1;
    p = t + LAT;
    push(p, K_PRESS, 0);
    for (int i = 0; i < 6; i++) push(p + offs[i], K_REP, 0);
    push(p + 27 + LAT, K_REL, 0);
    step(p + 15 - cyc);
    key_n[0] = 1'b1;          // high for sampling edges p+16, p+17
    step(2);
    key_n[0] = 1'b0;
    step(p + 26 - cyc);
    key_n[0] = 1'b1;          // real release sampled at p+27
    step(10);
  endtask

  task automatic reset_mid_hold_test();
    int t;
    int p;
    int k;
    key_n[1] = 1'b0;
    t = cyc + 1;
    p = t + LAT;
    push(p, K_PRESS, 1);
    push(p + 10, K_REP, 1);
    push(p + 13, K_REP, 1);
    step(p + 14 - cyc);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_level", key_level, '0);
    chk("async_rst_press", press_pulse, '0);
    chk("async_rst_release", release_pulse, '0);
    chk("async_rst_repeat", repeat_pulse, '0);
    step(3);
    rst_n = 1'b1;
    k = cyc;
    push(k + 1 + LAT, K_PRESS, 1);
    step(LAT + 3);
    push(cyc + 1 + LAT, K_REL, 1);
    key_n[1] = 1'b1;
    step(10);
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = '1;
    step(3);
    chk("reset_level", key_level, '0);
    chk("reset_press", press_pulse, '0);
    rst_n = 1'b1;
    step(50);

    // bounce: two 3-cycle lows separated by one high, never accepted
    key_n[0] = 1'b0; step(3);
    key_n[0] = 1'b1; step(1);
    key_n[0] = 1'b0; step(3);
    key_n[0] = 1'b1; step(10);

    hold_keys(2'b01, 6);      // clean press after the bounce
    hold_keys(2'b01, 34);     // auto-repeat: pin rises 28 cycles after press
    hold_keys(2'b11, 8);      // simultaneous press on both keys
    glitch_test();
    reset_mid_hold_test();

    step(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expect: got %0d unmatched expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
